vga_pixel_out: RTL and testbench
================================

# vga_pixel_out

Display-side endpoint of the object drawing chain. It generates the 640x480@60 raster (pixel coordinates issued to every drawer) and consumes the registered 8-bit RGB332 colour produced by `objects_mux`. It delays sync and blank to match the drawer/mux pipeline and drives the board's 4-bit-per-channel VGA DAC with aligned hsync/vsync. `clk` is the 25.175/25 MHz pixel clock: one pixel per cycle.

## Interface
- H_ACTIVE, 640, visible pixels per line
- H_FP / H_SYNC / H_BP, 16 / 96 / 48, horizontal porch and sync widths (H_TOTAL = 800)
- V_ACTIVE, 480, visible lines
- V_FP / V_SYNC / V_BP, 10 / 2 / 33, vertical porch and sync widths (V_TOTAL = 525)
- PIPE_LAT, 1, cycles from pixelX/pixelY issue to a valid RGBIn (legal range 0..4)
- clk  in  1  pixel clock
- reset  in  1  asynchronous, active-high reset
- RGBIn  in  8  RGB332 colour from objects_mux: [7:5] R, [4:2] G, [1:0] B
- pixelX  out  11  current horizontal count, 0..H_TOTAL-1, valid in blanking too
- pixelY  out  11  current vertical count, 0..V_TOTAL-1
- startOfFrame  out  1  one-cycle pulse at start of vertical blank (object update strobe)
- hsync, vsync  out  1 each  active-low sync
- blankN  out  1  high during visible pixels (aligned to colour outputs)
- red, green, blue  out  4 each  DAC colour

## Operation
- hCnt/vCnt are registered counters and drive pixelX/pixelY directly.
- hCnt increments every cycle. At H_TOTAL-1 it wraps to 0 and vCnt increments.
- vCnt wraps to 0 when vCnt = V_TOTAL-1 and hCnt = H_TOTAL-1.
- Raw raster signals, derived combinationally from the counters:
  - active: hCnt < H_ACTIVE and vCnt < V_ACTIVE.
  - hsyncRaw: low for H_ACTIVE+H_FP ≤ hCnt < H_ACTIVE+H_FP+H_SYNC (656..751).
  - vsyncRaw: low for V_ACTIVE+V_FP ≤ vCnt < V_ACTIVE+V_FP+V_SYNC (490..491).
- startOfFrame: registered, high for exactly one cycle following the cycle where hCnt = 0 and vCnt = V_ACTIVE.
- active, hsyncRaw and vsyncRaw pass through a PIPE_LAT-stage delay line, then the output register.
- Colour expansion, registered together with sync and blank:
  - red = {R, R[2]}
  - green = {G, G[2]}
  - blue = {B, B}
- When the delayed active is 0, red/green/blue are forced to 0 regardless of RGBIn.
- Elaboration check: H_TOTAL and V_TOTAL must be ≤ 2048. Violation is a fatal error.

## Timing
- Reset values:
  - pixelX = pixelY = 0, startOfFrame = 0
  - hsync = vsync = 1, blankN = 0
  - red = green = blue = 0
  - every delay-line stage holds inactive (sync = 1, active = 0)
- Reset acts asynchronously on all state. Mid-frame reset returns every output to its reset value immediately.
- First cycle after reset deassertion: pixelX = 0, pixelY = 0.
- Latency: the coordinate issued in cycle t produces hsync/vsync/blankN/colour in cycle t+PIPE_LAT+1. With the default, this is t+2.
- RGBIn is sampled at the end of cycle t+PIPE_LAT. RGBIn in any other cycle must not affect that pixel.
- No backpressure. The raster never stalls.
- Line period is 800 cycles; frame period is 420000 cycles.

## Structure
- Shared package vga_pkg holds:
  - default timing localparams (H_/V_ active, porch and sync values, H_TOTAL, V_TOTAL)
  - the RGB332 channel-slice constants
  - function rgb332_to_444
- One sub-module, vga_delay_line: parameterized WIDTH/DEPTH shift register with async active-high reset to a parameterized RESET_VALUE. It is instantiated for {active, hsyncRaw, vsyncRaw}. DEPTH = 0 is a pass-through.

## Test plan
- Reset release, default params:
  - cycle 0: pixelX = 0, pixelY = 0.
  - blankN = 0, hsync = vsync = 1 in cycles 0–1.
  - cycle 2: blankN = 1.
- Horizontal timing:
  - hsync low for exactly 96 cycles, starting 658 cycles after a line's pixelX = 0.
  - blankN high for 640 consecutive cycles per visible line.
  - pixelX wraps 799 → 0 while pixelY increments.
- Vertical timing:
  - vsync low for exactly 1600 cycles starting at line 490 (+2 cycle offset).
  - startOfFrame pulses once per 420000 cycles, one cycle after pixelY = 480, pixelX = 0.
- Colour expansion:
  - RGBIn = 8'b111_000_11 → red = F, green = 0, blue = F.
  - RGBIn = 8'b100_010_01 → red = 4'b1001, green = 4'b0100, blue = 4'b0101.
  - Same RGBIn during blanking → all 0.
- Alignment: the bench models a registered mux with RGBIn <= pixelX[7:0] each cycle. For x in 0..255, the displayed pixel x shows colour x, with no off-by-one at line start or end.
- Mid-frame reset: reset asserted asynchronously at (300, 200):
  - all outputs go to reset values before the next clk edge.
  - after release, the raster restarts at (0, 0) and blankN rises 2 cycles later.

Source files
------------

// File: rtl/vga_pkg.sv
// Shared VGA definitions: default 640x480@60 raster timing, RGB332 field positions
// and the RGB332 -> 4:4:4 DAC colour expansion.
package vga_pkg;

    localparam int H_ACTIVE_DEF = 640;
    localparam int H_FP_DEF     = 16;
    localparam int H_SYNC_DEF   = 96;
    localparam int H_BP_DEF     = 48;
    localparam int H_TOTAL_DEF  = H_ACTIVE_DEF + H_FP_DEF + H_SYNC_DEF + H_BP_DEF;

    localparam int V_ACTIVE_DEF = 480;
    localparam int V_FP_DEF     = 10;
    localparam int V_SYNC_DEF   = 2;
    localparam int V_BP_DEF     = 33;
    localparam int V_TOTAL_DEF  = V_ACTIVE_DEF + V_FP_DEF + V_SYNC_DEF + V_BP_DEF;

    localparam int CNT_W     = 11;
    localparam int CNT_LIMIT = 2048;

    localparam int R_MSB = 7;
    localparam int R_LSB = 5;
    localparam int G_MSB = 4;
    localparam int G_LSB = 2;
    localparam int B_MSB = 1;
    localparam int B_LSB = 0;

    typedef struct packed {
        logic [3:0] r;
        logic [3:0] g;
        logic [3:0] b;
    } rgb444_t;

    // Raster control bits as carried through the delay line.
    typedef struct packed {
        logic active;
        logic hsync;
        logic vsync;
    } raster_t;

    localparam raster_t RASTER_IDLE = '{active: 1'b0, hsync: 1'b1, vsync: 1'b1};

    // Replicate the top bits into the low bits so full-scale codes reach 4'hF.
    function automatic rgb444_t rgb332_to_444(input logic [7:0] c);
        rgb444_t o;
        o.r = {c[R_MSB:R_LSB], c[R_MSB]};
        o.g = {c[G_MSB:G_LSB], c[G_MSB]};
        o.b = {c[B_MSB:B_LSB], c[B_MSB:B_LSB]};
        return o;
    endfunction

endpackage

// File: rtl/vga_delay_line.sv
// Fixed-depth shift register with asynchronous reset to RESET_VALUE; DEPTH = 0
// degenerates to a wire.
module vga_delay_line #(
    parameter int               WIDTH       = 1,
    parameter int               DEPTH       = 1,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    generate
        if (DEPTH == 0) begin : g_pass
            assign q = d;
        end else begin : g_shift
            logic [WIDTH-1:0] stage_q [DEPTH];
            logic [WIDTH-1:0] stage_d [DEPTH];

            always_comb begin
                stage_d[0] = d;
                for (int i = 1; i < DEPTH; i++) begin
                    stage_d[i] = stage_q[i-1];
                end
            end

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    for (int i = 0; i < DEPTH; i++) begin
                        stage_q[i] <= RESET_VALUE;
                    end
                end else begin
                    for (int i = 0; i < DEPTH; i++) begin
                        stage_q[i] <= stage_d[i];
                    end
                end
            end

            assign q = stage_q[DEPTH-1];
        end
    endgenerate

endmodule

// File: rtl/vga_pixel_out.sv
// VGA raster generator and display endpoint: issues pixel coordinates, delays
// sync/blank to match the drawer pipeline and drives the 4:4:4 DAC.
module vga_pixel_out
    import vga_pkg::*;
#(
    parameter int H_ACTIVE = H_ACTIVE_DEF,
    parameter int H_FP     = H_FP_DEF,
    parameter int H_SYNC   = H_SYNC_DEF,
    parameter int H_BP     = H_BP_DEF,
    parameter int V_ACTIVE = V_ACTIVE_DEF,
    parameter int V_FP     = V_FP_DEF,
    parameter int V_SYNC   = V_SYNC_DEF,
    parameter int V_BP     = V_BP_DEF,
    parameter int PIPE_LAT = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [7:0]       RGBIn,
    output logic [CNT_W-1:0] pixelX,
    output logic [CNT_W-1:0] pixelY,
    output logic             startOfFrame,
    output logic             hsync,
    output logic             vsync,
    output logic             blankN,
    output logic [3:0]       red,
    output logic [3:0]       green,
    output logic [3:0]       blue
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [CNT_W-1:0] H_LAST    = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST    = CNT_W'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0] H_VIS     = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0] V_VIS     = CNT_W'(V_ACTIVE);
    localparam logic [CNT_W-1:0] HS_START  = CNT_W'(H_ACTIVE + H_FP);
    localparam logic [CNT_W-1:0] HS_END    = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CNT_W-1:0] VS_START  = CNT_W'(V_ACTIVE + V_FP);
    localparam logic [CNT_W-1:0] VS_END    = CNT_W'(V_ACTIVE + V_FP + V_SYNC);

    generate
        if (H_TOTAL > CNT_LIMIT || V_TOTAL > CNT_LIMIT) begin : g_bad_total
            $fatal(1, "vga_pixel_out: H_TOTAL/V_TOTAL exceed counter range");
        end
        if (PIPE_LAT < 0 || PIPE_LAT > 4) begin : g_bad_lat
            $fatal(1, "vga_pixel_out: PIPE_LAT outside 0..4");
        end
    endgenerate

    logic [CNT_W-1:0] h_cnt_q, h_cnt_d;
    logic [CNT_W-1:0] v_cnt_q, v_cnt_d;
    logic             sof_q, sof_d;
    raster_t          raw_s, dly_s;
    logic             hsync_q, hsync_d, vsync_q, vsync_d, blank_n_q, blank_n_d;
    rgb444_t          rgb_q, rgb_d;

    // Raster counters and the raw, undelayed raster controls.
    always_comb begin
        h_cnt_d = h_cnt_q + 11'd1;
        v_cnt_d = v_cnt_q;
        if (h_cnt_q == H_LAST) begin
            h_cnt_d = 11'd0;
            if (v_cnt_q == V_LAST) begin
                v_cnt_d = 11'd0;
            end else begin
                v_cnt_d = v_cnt_q + 11'd1;
            end
        end else begin
            v_cnt_d = v_cnt_q;
        end
        sof_d        = (h_cnt_q == 11'd0) && (v_cnt_q == V_VIS);
        raw_s.active = (h_cnt_q < H_VIS) && (v_cnt_q < V_VIS);
        raw_s.hsync  = !((h_cnt_q >= HS_START) && (h_cnt_q < HS_END));
        raw_s.vsync  = !((v_cnt_q >= VS_START) && (v_cnt_q < VS_END));
    end

    vga_delay_line #(
        .WIDTH       (3),
        .DEPTH       (PIPE_LAT),
        .RESET_VALUE (RASTER_IDLE)
    ) u_raster_dly (
        .clk (clk),
        .rst (reset),
        .d   (raw_s),
        .q   (dly_s)
    );

    // Output stage: colour is sampled on the same edge that registers the delayed controls.
    always_comb begin
        hsync_d   = dly_s.hsync;
        vsync_d   = dly_s.vsync;
        blank_n_d = dly_s.active;
        if (dly_s.active) begin
            rgb_d = rgb332_to_444(RGBIn);
        end else begin
            rgb_d = '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            h_cnt_q   <= 11'd0;
            v_cnt_q   <= 11'd0;
            sof_q     <= 1'b0;
            hsync_q   <= 1'b1;
            vsync_q   <= 1'b1;
            blank_n_q <= 1'b0;
            rgb_q     <= '0;
        end else begin
            h_cnt_q   <= h_cnt_d;
            v_cnt_q   <= v_cnt_d;
            sof_q     <= sof_d;
            hsync_q   <= hsync_d;
            vsync_q   <= vsync_d;
            blank_n_q <= blank_n_d;
            rgb_q     <= rgb_d;
        end
    end

    assign pixelX       = h_cnt_q;
    assign pixelY       = v_cnt_q;
    assign startOfFrame = sof_q;
    assign hsync        = hsync_q;
    assign vsync        = vsync_q;
    assign blankN       = blank_n_q;
    assign red          = rgb_q.r;
    assign green        = rgb_q.g;
    assign blue         = rgb_q.b;

endmodule

// File: tb/tb_vga_pixel_out.sv
// Directed bench for vga_pixel_out. Horizontal timing is the default 800-cycle line;
// the vertical frame is shortened (20 visible lines, 27 total) so whole frames run quickly.
module tb_vga_pixel_out;

    localparam int TB_V_ACTIVE = 20;
    localparam int TB_V_FP     = 2;
    localparam int TB_V_SYNC   = 2;
    localparam int TB_V_BP     = 3;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [7:0]  rgb_in;
    logic [10:0] pixelX, pixelY;
    logic        startOfFrame, hsync, vsync, blankN;
    logic [3:0]  red, green, blue;

    logic        use_x = 1'b0;
    logic [7:0]  const_rgb = 8'h00;
    int          n_cmp = 0;
    int          n_fail = 0;
    int          cyc = 0;

    vga_pixel_out #(
        .V_ACTIVE (TB_V_ACTIVE),
        .V_FP     (TB_V_FP),
        .V_SYNC   (TB_V_SYNC),
        .V_BP     (TB_V_BP)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .RGBIn        (rgb_in),
        .pixelX       (pixelX),
        .pixelY       (pixelY),
        .startOfFrame (startOfFrame),
        .hsync        (hsync),
        .vsync        (vsync),
        .blankN       (blankN),
        .red          (red),
        .green        (green),
        .blue         (blue)
    );

    always #5 clk = ~clk;

    // Registered objects_mux stand-in: either a fixed colour or the current pixelX.
    always @(posedge clk) rgb_in <= use_x ? pixelX[7:0] : const_rgb;

    task automatic step(input int n);
        repeat (n) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        cyc = 0;
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        n_cmp++;
        if (pixelX !== 11'd0 || pixelY !== 11'd0 || startOfFrame !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_counters: x=%0d y=%0d sof=%b, want 0 0 0", pixelX, pixelY, startOfFrame);
        end
        n_cmp++;
        if ({hsync, vsync, blankN} !== 3'b110 || {red, green, blue} !== 12'h000) begin
            n_fail++;
            $display("FAIL reset_outputs: hs/vs/bn=%b rgb=%h, want 110 000", {hsync, vsync, blankN}, {red, green, blue});
        end
        reset = 1'b0;
        cyc = 0;
        #1;
        n_cmp++;
        if (pixelX !== 11'd0 || pixelY !== 11'd0 || {hsync, vsync, blankN} !== 3'b110) begin
            n_fail++;
            $display("FAIL release_cyc0: x=%0d y=%0d hs/vs/bn=%b, want 0 0 110", pixelX, pixelY, {hsync, vsync, blankN});
        end
        step(1);
        n_cmp++;
        if (pixelX !== 11'd1 || {hsync, vsync, blankN} !== 3'b110) begin
            n_fail++;
            $display("FAIL release_cyc1: x=%0d hs/vs/bn=%b, want 1 110", pixelX, {hsync, vsync, blankN});
        end
        step(1);
        n_cmp++;
        if (blankN !== 1'b1) begin
            n_fail++;
            $display("FAIL release_cyc2_blank: blankN=%b, want 1", blankN);
        end
    endtask

    task automatic test_horizontal();
        int hs_first = -1, hs_cnt = 0, bn_first = -1, bn_cnt = 0;
        use_x = 1'b0;
        do_reset();
        for (int i = 0; i <= 801; i++) begin
            if (i > 0) step(1);
            if (hsync === 1'b0) begin
                if (hs_first < 0) hs_first = i;
                hs_cnt++;
            end
            if (blankN === 1'b1) begin
                if (bn_first < 0) bn_first = i;
                bn_cnt++;
            end
            if (i == 799) begin
                n_cmp++;
                if (pixelX !== 11'd799 || pixelY !== 11'd0) begin
                    n_fail++;
                    $display("FAIL h_last: x=%0d y=%0d, want 799 0", pixelX, pixelY);
                end
            end
            if (i == 800) begin
                n_cmp++;
                if (pixelX !== 11'd0 || pixelY !== 11'd1) begin
                    n_fail++;
                    $display("FAIL h_wrap: x=%0d y=%0d, want 0 1", pixelX, pixelY);
                end
            end
        end
        n_cmp++;
        if (hs_first !== 658 || hs_cnt !== 96) begin
            n_fail++;
            $display("FAIL hsync_window: start=%0d len=%0d, want 658 96", hs_first, hs_cnt);
        end
        n_cmp++;
        if (bn_first !== 2 || bn_cnt !== 640) begin
            n_fail++;
            $display("FAIL blank_window: start=%0d len=%0d, want 2 640", bn_first, bn_cnt);
        end
    endtask

    task automatic test_vertical();
        int vs_first = -1, vs_cnt = 0, sof_first = -1, sof_second = -1, sof_cnt = 0;
        use_x = 1'b0;
        do_reset();
        for (int i = 0; i <= 37700; i++) begin
            if (i > 0) step(1);
            if (vsync === 1'b0) begin
                if (vs_first < 0) vs_first = i;
                vs_cnt++;
            end
            if (startOfFrame === 1'b1) begin
                if (sof_cnt == 0) sof_first = i;
                if (sof_cnt == 1) sof_second = i;
                sof_cnt++;
            end
            if (i == 21599) begin
                n_cmp++;
                if (pixelX !== 11'd799 || pixelY !== 11'd26) begin
                    n_fail++;
                    $display("FAIL v_last: x=%0d y=%0d, want 799 26", pixelX, pixelY);
                end
            end
            if (i == 21600) begin
                n_cmp++;
                if (pixelX !== 11'd0 || pixelY !== 11'd0) begin
                    n_fail++;
                    $display("FAIL v_wrap: x=%0d y=%0d, want 0 0", pixelX, pixelY);
                end
            end
        end
        n_cmp++;
        if (vs_first !== 17602 || vs_cnt !== 1600) begin
            n_fail++;
            $display("FAIL vsync_window: start=%0d len=%0d, want 17602 1600", vs_first, vs_cnt);
        end
        n_cmp++;
        if (sof_first !== 16001 || sof_second !== 37601 || sof_cnt !== 2) begin
            n_fail++;
            $display("FAIL sof_pulse: first=%0d second=%0d count=%0d, want 16001 37601 2", sof_first, sof_second, sof_cnt);
        end
    endtask

    task automatic test_colour();
        use_x = 1'b0;
        const_rgb = 8'b111_000_11;
        do_reset();
        step(10);
        n_cmp++;
        if (blankN !== 1'b1 || red !== 4'hF || green !== 4'h0 || blue !== 4'hF) begin
            n_fail++;
            $display("FAIL colour_e3: bn=%b rgb=%h, want 1 f0f", blankN, {red, green, blue});
        end
        const_rgb = 8'b100_010_01;
        step(3);
        n_cmp++;
        if (red !== 4'b1001 || green !== 4'b0100 || blue !== 4'b0101) begin
            n_fail++;
            $display("FAIL colour_89: rgb=%h, want 945", {red, green, blue});
        end
        step(641 - cyc);
        n_cmp++;
        if (blankN !== 1'b1 || {red, green, blue} !== 12'h945) begin
            n_fail++;
            $display("FAIL colour_last_visible: bn=%b rgb=%h, want 1 945", blankN, {red, green, blue});
        end
        step(702 - cyc);
        n_cmp++;
        if (blankN !== 1'b0 || {red, green, blue} !== 12'h000) begin
            n_fail++;
            $display("FAIL colour_blanked: bn=%b rgb=%h, want 0 000", blankN, {red, green, blue});
        end
    endtask

    task automatic test_alignment();
        logic [7:0]  v;
        logic [11:0] want;
        use_x = 1'b1;
        do_reset();
        step(2);
        for (int x = 0; x < 256; x++) begin
            v = 8'(x);
            want = {v[7:5], v[7], v[4:2], v[4], v[1:0], v[1:0]};
            n_cmp++;
            if (blankN !== 1'b1 || {red, green, blue} !== want) begin
                n_fail++;
                $display("FAIL align_x%0d: bn=%b rgb=%h, want 1 %h", x, blankN, {red, green, blue}, want);
            end
            step(1);
        end
        step(641 - cyc);
        n_cmp++;
        if (blankN !== 1'b1 || {red, green, blue} !== 12'h6FF) begin
            n_fail++;
            $display("FAIL align_x639: bn=%b rgb=%h, want 1 6ff", blankN, {red, green, blue});
        end
        step(1);
        n_cmp++;
        if (blankN !== 1'b0 || {red, green, blue} !== 12'h000) begin
            n_fail++;
            $display("FAIL align_x640: bn=%b rgb=%h, want 0 000", blankN, {red, green, blue});
        end
        step(801 - cyc);
        n_cmp++;
        if (blankN !== 1'b0) begin
            n_fail++;
            $display("FAIL align_pre_line1: bn=%b, want 0", blankN);
        end
        step(1);
        n_cmp++;
        if (blankN !== 1'b1 || {red, green, blue} !== 12'h000) begin
            n_fail++;
            $display("FAIL align_line1_x0: bn=%b rgb=%h, want 1 000", blankN, {red, green, blue});
        end
        step(1);
        n_cmp++;
        if (blankN !== 1'b1 || {red, green, blue} !== 12'h005) begin
            n_fail++;
            $display("FAIL align_line1_x1: bn=%b rgb=%h, want 1 005", blankN, {red, green, blue});
        end
    endtask

    task automatic test_midframe_reset();
        use_x = 1'b0;
        const_rgb = 8'hFF;
        do_reset();
        step(8300);
        n_cmp++;
        if (pixelX !== 11'd300 || pixelY !== 11'd10 || blankN !== 1'b1 || red !== 4'hF) begin
            n_fail++;
            $display("FAIL mid_pre: x=%0d y=%0d bn=%b r=%h, want 300 10 1 f", pixelX, pixelY, blankN, red);
        end
        #2;
        reset = 1'b1;
        #1;
        n_cmp++;
        if (pixelX !== 11'd0 || pixelY !== 11'd0 || startOfFrame !== 1'b0 ||
            {hsync, vsync, blankN} !== 3'b110 || {red, green, blue} !== 12'h000) begin
            n_fail++;
            $display("FAIL mid_async: x=%0d y=%0d sof=%b hs/vs/bn=%b rgb=%h, want 0 0 0 110 000",
                     pixelX, pixelY, startOfFrame, {hsync, vsync, blankN}, {red, green, blue});
        end
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        cyc = 0;
        #1;
        n_cmp++;
        if (pixelX !== 11'd0 || pixelY !== 11'd0 || blankN !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_restart: x=%0d y=%0d bn=%b, want 0 0 0", pixelX, pixelY, blankN);
        end
        step(1);
        n_cmp++;
        if (blankN !== 1'b0 || pixelX !== 11'd1) begin
            n_fail++;
            $display("FAIL mid_cyc1: x=%0d bn=%b, want 1 0", pixelX, blankN);
        end
        step(1);
        n_cmp++;
        if (blankN !== 1'b1 || red !== 4'hF) begin
            n_fail++;
            $display("FAIL mid_cyc2: bn=%b r=%h, want 1 f", blankN, red);
        end
    endtask

    initial begin
        test_reset();
        test_horizontal();
        test_vertical();
        test_colour();
        test_alignment();
        test_midframe_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
